sp256k_ctrl: RTL and testbench
==============================

# sp256k_ctrl

Word-access controller that drives one 16K x 16 single-port SRAM macro (SP256K interface) from the MCU's 32-bit memory request port. Each accepted 32-bit request becomes two sequential 16-bit SRAM accesses (low half, then high half) with per-byte write masking. Read data is reassembled and returned with a one-cycle valid pulse. After a programmable run of idle cycles, the controller puts the macro into standby and wakes it on the next request.

## Interface
- IDLE_STDBY_CYCLES, 16: consecutive idle cycles before the macro enters standby; 0 disables standby.
- clk  in  1  system clock; all logic on rising edge
- sync_reset  in  1  synchronous, active-high reset
- mem_req  in  1  request strobe; accepted when mem_req & mem_ready
- mem_ready  out  1  controller can accept a request this cycle
- mem_we  in  1  1 = write, 0 = read
- mem_be  in  4  byte enables for writes, bit n covers mem_wdata[8n+7:8n]
- mem_addr  in  13  32-bit word address
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid only while mem_rvalid = 1
- mem_rvalid  out  1  one-cycle read-completion pulse
- sram_AD  out  14  SRAM half-word address
- sram_DI  out  16  SRAM write data
- sram_MASKWE  out  4  SRAM nibble write mask
- sram_WE  out  1  SRAM write enable
- sram_CS  out  1  SRAM chip select
- sram_STDBY  out  1  SRAM standby
- sram_SLEEP  out  1  tied 0
- sram_PWROFF_N  out  1  tied 1
- sram_DO  in  16  SRAM read data, registered in the macro with 1-cycle latency

## Operation
- All request fields are captured at acceptance. The requester may change them afterwards.
- States: IDLE, STBY, WAKE, LO, HI, RD_LAST.
  - mem_ready = 1 in IDLE and STBY only.
- IDLE transitions:
  - on accept, go to LO.
  - otherwise, increment the idle counter.
  - when the counter reaches IDLE_STDBY_CYCLES (parameter ≠ 0), go to STBY and clear the counter.
- STBY: sram_STDBY = 1, sram_CS = 0. On accept, go to WAKE. WAKE drives sram_STDBY = 0 and sram_CS = 0 for one cycle, then goes to LO.
- LO drives these registered SRAM outputs:
  - sram_CS = 1, sram_AD = {addr, 1'b0}, sram_DI = wdata[15:0]
  - sram_WE = we, sram_MASKWE = {be[1], be[1], be[0], be[0]}
- HI drives:
  - sram_AD = {addr, 1'b1}, sram_DI = wdata[31:16]
  - sram_MASKWE = {be[3], be[3], be[2], be[2]}
- After HI:
  - a write returns to IDLE.
  - a read goes to RD_LAST.
- Read data path:
  - during HI, sram_DO holds the low half; it is latched at the end of HI.
  - during RD_LAST, sram_DO holds the high half.
  - at the end of RD_LAST, mem_rdata = {sram_DO, low_latched}, mem_rvalid = 1 for the next cycle, and the state goes to IDLE.
- For reads, sram_MASKWE = 0 and sram_WE = 0.
- A write with mem_be = 4'b0000 runs the full sequence with sram_MASKWE = 0, so memory is unchanged.
- Outside LO and HI, sram_CS = 0, sram_WE = 0 and sram_MASKWE = 0. sram_AD and sram_DI hold their last values.
- The idle counter clears on any accept and in every non-IDLE state.

## Timing
- Reset values:
  - state IDLE, mem_ready 1, mem_rvalid 0, mem_rdata 0
  - sram_AD 0, sram_DI 0, sram_MASKWE 0, sram_WE 0, sram_CS 0, sram_STDBY 0
  - sram_SLEEP 0, sram_PWROFF_N 1, idle counter 0
- Write accepted in cycle 0 from IDLE:
  - cycle 1 is the LO access, cycle 2 the HI access.
  - mem_ready = 1 again in cycle 3.
- Read accepted in cycle 0 from IDLE:
  - LO in cycle 1, HI in cycle 2, RD_LAST in cycle 3.
  - mem_rvalid = 1 with data in cycle 4. mem_ready is also 1 in cycle 4, so a request in cycle 4 is accepted.
- Requests accepted from STBY take 1 extra cycle (the WAKE cycle).
- Standby entry: with the parameter at 16 and no requests, sram_STDBY rises in the cycle after the 16th consecutive idle cycle.
- A request arriving in the same cycle the counter reaches its threshold is accepted. It goes to LO, not STBY.
- sync_reset in any state forces the reset values at the next edge:
  - a pending mem_rvalid is dropped.
  - an interrupted write may leave only the low half written. This is accepted behaviour.

## Test plan
- Write addr 13'h0005, data 32'hDEAD_BEEF, be 4'hF, then read addr 5:
  - sram_AD 14'h000A then 14'h000B with DI 16'hBEEF then 16'hDEAD.
  - mem_rdata = 32'hDEAD_BEEF with mem_rvalid in the 4th cycle after the read is accepted.
- Partial write: preload 32'h1122_3344 at addr 7, write 32'hAABB_CCDD with be 4'b0101, read back -> 32'h11BB_33DD. MASKWE must be 4'b0011 in LO and 4'b0011 in HI.
- Read accepted in cycle 0 and a second read presented in cycle 4 -> second read accepted in cycle 4; two mem_rvalid pulses exactly 4 cycles apart.
- Idle 16 cycles -> sram_STDBY = 1 with CS = 0. A read then gets a 1-cycle WAKE (STDBY 0, CS 0) before LO; mem_rvalid arrives 5 cycles after acceptance.
- Assert sync_reset during HI of a read -> no mem_rvalid. The next cycle shows the reset values, and a following read returns correct data.
- IDLE_STDBY_CYCLES = 0, 100 idle cycles -> sram_STDBY stays 0.

Source files
------------

// File: rtl/sp256k_ctrl_if.sv
// Purpose : MCU-side 32-bit word request/response bus for the SP256K word controller.
// Latency : none (signal bundle only).
// Backpressure: the requester holds mem_req until mem_ready; read data returns as a one-cycle mem_rvalid pulse.
// Ports   : mem_req/mem_we/mem_be/mem_addr/mem_wdata (requester -> controller),
//           mem_ready/mem_rdata/mem_rvalid (controller -> requester).
interface sp256k_ctrl_if;
   logic        mem_req;
   logic        mem_ready;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [12:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata, mem_rvalid
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ready, mem_rdata, mem_rvalid
   );
endinterface

// File: rtl/sp256k_ctrl.sv
// Purpose : drives a 16K x 16 SP256K SRAM from a 32-bit word port (two half-word accesses per request).
// Latency : write busy 2 cycles after accept; read data valid 4 cycles after accept (+1 if woken from standby).
// Backpressure: mem_ready is high only in IDLE/STBY; requests are held off while an access is in flight.
// Ports   : clk, sync_reset (sync, active high); mem (sp256k_ctrl_if.slave);
//           sram_AD/DI/MASKWE/WE/CS/STDBY/SLEEP/PWROFF_N to the macro, sram_DO from the macro.
module sp256k_ctrl #(
   parameter int unsigned IDLE_STDBY_CYCLES = 16
) (
   input  logic                clk,
   input  logic                sync_reset,
   sp256k_ctrl_if.slave        mem,
   output logic [13:0]         sram_AD,
   output logic [15:0]         sram_DI,
   output logic [3:0]          sram_MASKWE,
   output logic                sram_WE,
   output logic                sram_CS,
   output logic                sram_STDBY,
   output logic                sram_SLEEP,
   output logic                sram_PWROFF_N,
   input  logic [15:0]         sram_DO
);

   // Counter only needs to reach IDLE_STDBY_CYCLES-1: standby is entered on the
   // idle cycle that would make the run IDLE_STDBY_CYCLES long.
   localparam int unsigned    CW        = (IDLE_STDBY_CYCLES > 1) ? $clog2(IDLE_STDBY_CYCLES) : 1;
   localparam logic [CW-1:0]  IDLE_LAST = CW'((IDLE_STDBY_CYCLES == 0) ? 0 : IDLE_STDBY_CYCLES - 1);
   localparam bit             STDBY_EN  = (IDLE_STDBY_CYCLES != 0);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      STBY    = 3'd1,
      WAKE    = 3'd2,
      LO      = 3'd3,
      HI      = 3'd4,
      RD_LAST = 3'd5
   } state_t;

   state_t        state;
   logic [CW-1:0] idle_cnt;
   logic [12:0]   addr_q;
   logic          we_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic [15:0]   low_q;

   logic          accept;
   logic          lo_from_bus;
   logic [12:0]   lo_addr;
   logic          lo_we;
   logic [3:0]    lo_be;
   logic [15:0]   lo_di;
   logic [3:0]    lo_mask;
   logic [3:0]    hi_mask;

   assign accept = mem.mem_req & mem.mem_ready;

   // From IDLE the LO access is issued on the accepting edge, so its fields
   // come straight off the bus; after WAKE they come from the captured copy.
   assign lo_from_bus = (state == IDLE);
   assign lo_addr     = lo_from_bus ? mem.mem_addr        : addr_q;
   assign lo_we       = lo_from_bus ? mem.mem_we          : we_q;
   assign lo_be       = lo_from_bus ? mem.mem_be          : be_q;
   assign lo_di       = lo_from_bus ? mem.mem_wdata[15:0] : wdata_q[15:0];

   // One byte enable covers two SRAM nibbles; reads never assert the mask.
   assign lo_mask = lo_we ? {lo_be[1], lo_be[1], lo_be[0], lo_be[0]} : 4'b0000;
   assign hi_mask = we_q  ? {be_q[3], be_q[3], be_q[2], be_q[2]}     : 4'b0000;

   assign sram_SLEEP    = 1'b0;
   assign sram_PWROFF_N = 1'b1;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state          <= IDLE;
         idle_cnt       <= '0;
         addr_q         <= '0;
         we_q           <= 1'b0;
         be_q           <= '0;
         wdata_q        <= '0;
         low_q          <= '0;
         mem.mem_ready  <= 1'b1;
         mem.mem_rvalid <= 1'b0;
         mem.mem_rdata  <= '0;
         sram_AD        <= '0;
         sram_DI        <= '0;
         sram_MASKWE    <= '0;
         sram_WE        <= 1'b0;
         sram_CS        <= 1'b0;
         sram_STDBY     <= 1'b0;
      end else begin
         mem.mem_rvalid <= 1'b0;
         idle_cnt       <= '0;

         if (accept) begin
            addr_q  <= mem.mem_addr;
            we_q    <= mem.mem_we;
            be_q    <= mem.mem_be;
            wdata_q <= mem.mem_wdata;
         end

         unique case (state)
            IDLE: begin
               if (accept) begin
                  state         <= LO;
                  mem.mem_ready <= 1'b0;
                  sram_CS       <= 1'b1;
                  sram_AD       <= {lo_addr, 1'b0};
                  sram_DI       <= lo_di;
                  sram_WE       <= lo_we;
                  sram_MASKWE   <= lo_mask;
               end else if (STDBY_EN && (idle_cnt == IDLE_LAST)) begin
                  state      <= STBY;
                  sram_STDBY <= 1'b1;
               end else if (STDBY_EN) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

            STBY: begin
               if (accept) begin
                  state         <= WAKE;
                  mem.mem_ready <= 1'b0;
                  sram_STDBY    <= 1'b0;
               end
            end

            // Macro leaves standby here; first access follows next cycle.
            WAKE: begin
               state       <= LO;
               sram_CS     <= 1'b1;
               sram_AD     <= {lo_addr, 1'b0};
               sram_DI     <= lo_di;
               sram_WE     <= lo_we;
               sram_MASKWE <= lo_mask;
            end

            LO: begin
               state       <= HI;
               sram_AD     <= {addr_q, 1'b1};
               sram_DI     <= wdata_q[31:16];
               sram_MASKWE <= hi_mask;
            end

            // sram_DO now carries the low half read during LO.
            HI: begin
               sram_CS     <= 1'b0;
               sram_WE     <= 1'b0;
               sram_MASKWE <= 4'b0000;
               if (we_q) begin
                  state         <= IDLE;
                  mem.mem_ready <= 1'b1;
               end else begin
                  state <= RD_LAST;
                  low_q <= sram_DO;
               end
            end

            // sram_DO now carries the high half read during HI.
            RD_LAST: begin
               state          <= IDLE;
               mem.mem_ready  <= 1'b1;
               mem.mem_rvalid <= 1'b1;
               mem.mem_rdata  <= {sram_DO, low_q};
            end

            default: begin
               state         <= IDLE;
               mem.mem_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp256k_ctrl.sv
// Purpose : self-checking bench for sp256k_ctrl with a behavioural SP256K macro and a word-level memory model.
// Latency : checks cycle-exact SRAM sequencing, read return timing and standby entry/wake.
// Backpressure: requests are only presented in cycles where mem_ready is expected high.
module tb_sp256k_ctrl;

   logic clk;
   logic sync_reset;

   sp256k_ctrl_if mem ();
   sp256k_ctrl_if mem0 ();

   logic [13:0] sram_AD;
   logic [15:0] sram_DI;
   logic [3:0]  sram_MASKWE;
   logic        sram_WE, sram_CS, sram_STDBY, sram_SLEEP, sram_PWROFF_N;
   logic [15:0] sram_DO;

   logic [13:0] sram_AD0;
   logic [15:0] sram_DI0;
   logic [3:0]  sram_MASKWE0;
   logic        sram_WE0, sram_CS0, sram_STDBY0, sram_SLEEP0, sram_PWROFF_N0;
   logic [15:0] sram_DO0;

   sp256k_ctrl #(.IDLE_STDBY_CYCLES(16)) dut (
      .clk          (clk),
      .sync_reset   (sync_reset),
      .mem          (mem),
      .sram_AD      (sram_AD),
      .sram_DI      (sram_DI),
      .sram_MASKWE  (sram_MASKWE),
      .sram_WE      (sram_WE),
      .sram_CS      (sram_CS),
      .sram_STDBY   (sram_STDBY),
      .sram_SLEEP   (sram_SLEEP),
      .sram_PWROFF_N(sram_PWROFF_N),
      .sram_DO      (sram_DO)
   );

   // Standby-disabled instance, left idle for the whole run.
   sp256k_ctrl #(.IDLE_STDBY_CYCLES(0)) dut0 (
      .clk          (clk),
      .sync_reset   (sync_reset),
      .mem          (mem0),
      .sram_AD      (sram_AD0),
      .sram_DI      (sram_DI0),
      .sram_MASKWE  (sram_MASKWE0),
      .sram_WE      (sram_WE0),
      .sram_CS      (sram_CS0),
      .sram_STDBY   (sram_STDBY0),
      .sram_SLEEP   (sram_SLEEP0),
      .sram_PWROFF_N(sram_PWROFF_N0),
      .sram_DO      (sram_DO0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural macro: nibble-masked write, registered read data.
   logic [15:0] sram_arr [16384];
   always @(posedge clk) begin
      if (sram_CS && !sram_STDBY) begin
         if (sram_WE) begin
            for (int k = 0; k < 4; k++)
               if (sram_MASKWE[k]) sram_arr[sram_AD][4*k +: 4] <= sram_DI[4*k +: 4];
         end
         sram_DO <= sram_arr[sram_AD];
      end
   end

   // Word-level reference memory, byte-enable granularity.
   logic [31:0] model [8192];

   int checks = 0;
   int errors = 0;
   int idle_run = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
      idle_run += n;
   endtask

   // Issues one request in the current cycle and follows it cycle by cycle to completion.
   task automatic access(input bit we, input logic [3:0] be, input logic [12:0] addr, input logic [31:0] wd);
      bit          wake;
      logic [3:0]  mlo, mhi;
      wake = (idle_run >= 16);
      mlo  = we ? {be[1], be[1], be[0], be[0]} : 4'b0000;
      mhi  = we ? {be[3], be[3], be[2], be[2]} : 4'b0000;
      check("acc_ready", mem.mem_ready, 1);
      mem.mem_req   = 1'b1;
      mem.mem_we    = we;
      mem.mem_be    = be;
      mem.mem_addr  = addr;
      mem.mem_wdata = wd;
      step();
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'($urandom);
      mem.mem_be    = 4'($urandom);
      mem.mem_addr  = 13'($urandom);
      mem.mem_wdata = $urandom;
      check("acc_rvalid_low", mem.mem_rvalid, 0);
      if (wake) begin
         check("wake_stdby", sram_STDBY, 0);
         check("wake_cs", sram_CS, 0);
         step();
      end
      check("lo_cs", sram_CS, 1);
      check("lo_we", sram_WE, we);
      check("lo_ad", sram_AD, {addr, 1'b0});
      check("lo_di", sram_DI, wd[15:0]);
      check("lo_mask", sram_MASKWE, mlo);
      check("lo_ready", mem.mem_ready, 0);
      step();
      check("hi_cs", sram_CS, 1);
      check("hi_ad", sram_AD, {addr, 1'b1});
      check("hi_di", sram_DI, wd[31:16]);
      check("hi_mask", sram_MASKWE, mhi);
      step();
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
         check("wr_done_ready", mem.mem_ready, 1);
         check("wr_done_cs", sram_CS, 0);
         check("wr_done_mask", sram_MASKWE, 0);
      end else begin
         check("rd_last_cs", sram_CS, 0);
         check("rd_last_rvalid", mem.mem_rvalid, 0);
         check("rd_last_ready", mem.mem_ready, 0);
         step();
         check("rd_rvalid", mem.mem_rvalid, 1);
         check("rd_data", mem.mem_rdata, model[addr]);
         check("rd_ready", mem.mem_ready, 1);
      end
      idle_run = 0;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) sram_arr[i] = 16'h0000;
      for (int i = 0; i < 8192; i++) model[i] = 32'h0;
      sram_DO0       = 16'h0000;
      mem.mem_req    = 1'b0;
      mem.mem_we     = 1'b0;
      mem.mem_be     = 4'h0;
      mem.mem_addr   = '0;
      mem.mem_wdata  = '0;
      mem0.mem_req   = 1'b0;
      mem0.mem_we    = 1'b0;
      mem0.mem_be    = 4'h0;
      mem0.mem_addr  = '0;
      mem0.mem_wdata = '0;
      sync_reset = 1'b1;
      step();
      step();
      sync_reset = 1'b0;
      idle_run = 0;

      // Reset values
      check("rst_ready", mem.mem_ready, 1);
      check("rst_rvalid", mem.mem_rvalid, 0);
      check("rst_rdata", mem.mem_rdata, 0);
      check("rst_ad", sram_AD, 0);
      check("rst_di", sram_DI, 0);
      check("rst_mask", sram_MASKWE, 0);
      check("rst_we", sram_WE, 0);
      check("rst_cs", sram_CS, 0);
      check("rst_stdby", sram_STDBY, 0);
      check("rst_sleep", sram_SLEEP, 0);
      check("rst_pwroff_n", sram_PWROFF_N, 1);

      // Full write then read
      access(1'b1, 4'hF, 13'h0005, 32'hDEAD_BEEF);
      access(1'b0, 4'h0, 13'h0005, 32'h0);
      check("dir_deadbeef", mem.mem_rdata, 32'hDEAD_BEEF);

      // Partial write, byte enables 0101
      access(1'b1, 4'hF, 13'h0007, 32'h1122_3344);
      access(1'b1, 4'b0101, 13'h0007, 32'hAABB_CCDD);
      access(1'b0, 4'h0, 13'h0007, 32'h0);
      check("dir_partial", mem.mem_rdata, 32'h11BB_33DD);

      // Zero byte enables leave memory unchanged
      access(1'b1, 4'h0, 13'h0005, 32'h0BAD_F00D);
      access(1'b0, 4'h0, 13'h0005, 32'h0);
      check("dir_be0", mem.mem_rdata, 32'hDEAD_BEEF);

      // Top word address
      access(1'b1, 4'hF, 13'h1FFF, 32'hCAFE_1234);
      access(1'b0, 4'h0, 13'h1FFF, 32'h0);
      check("dir_top", mem.mem_rdata, 32'hCAFE_1234);

      // Back-to-back reads: second issued in the rvalid cycle of the first
      access(1'b0, 4'h0, 13'h0005, 32'h0);
      check("b2b_ready", mem.mem_ready, 1);
      access(1'b0, 4'h0, 13'h0007, 32'h0);
      check("b2b_second", mem.mem_rdata, 32'h11BB_33DD);

      // Request in the threshold cycle goes straight to LO
      idle(15);
      check("thr_stdby", sram_STDBY, 0);
      access(1'b0, 4'h0, 13'h0005, 32'h0);

      // Standby entry after 16 idle cycles, then wake on a read
      idle(15);
      check("pre_stby", sram_STDBY, 0);
      idle(1);
      check("stby_stdby", sram_STDBY, 1);
      check("stby_cs", sram_CS, 0);
      check("stby_ready", mem.mem_ready, 1);
      idle(3);
      check("stby_hold", sram_STDBY, 1);
      access(1'b0, 4'h0, 13'h0007, 32'h0);

      // Reset during HI of a read
      check("rsthi_ready", mem.mem_ready, 1);
      mem.mem_req  = 1'b1;
      mem.mem_we   = 1'b0;
      mem.mem_addr = 13'h0005;
      step();
      mem.mem_req  = 1'b0;
      step();
      check("rsthi_in_hi", sram_AD, 14'h000B);
      sync_reset = 1'b1;
      step();
      sync_reset = 1'b0;
      idle_run = 0;
      check("rsthi_rvalid", mem.mem_rvalid, 0);
      check("rsthi_ready", mem.mem_ready, 1);
      check("rsthi_rdata", mem.mem_rdata, 0);
      check("rsthi_cs", sram_CS, 0);
      check("rsthi_ad", sram_AD, 0);
      check("rsthi_di", sram_DI, 0);
      check("rsthi_stdby", sram_STDBY, 0);
      idle(1);
      check("rsthi_rvalid2", mem.mem_rvalid, 0);
      idle(1);
      check("rsthi_rvalid3", mem.mem_rvalid, 0);
      access(1'b0, 4'h0, 13'h0007, 32'h0);

      // Randomized traffic against the word model, with occasional long gaps
      for (int n = 0; n < 60; n++) begin
         int          gap;
         logic [12:0] a;
         gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 2));
         idle(gap);
         a = ($urandom_range(0, 9) == 0) ? 13'(13'h1FF0 + $urandom_range(0, 15)) : 13'($urandom_range(0, 15));
         access(1'($urandom), 4'($urandom), a, $urandom);
      end

      // Standby-disabled instance never enters standby
      for (int i = 0; i < 100; i++) begin
         step();
         check("nostby_stdby", sram_STDBY0, 0);
      end
      check("nostby_ready", mem0.mem_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
